// File: rtl/ped_req_pkg.sv
// Shared types and constants for the pedestrian request controller.
// PED_REQ_LOCKOUT_EN adds the LOCKOUT state to the state enum.
package ped_req_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_SAT = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
`ifdef PED_REQ_LOCKOUT_EN
    ST_SERVING = 2'd2,
    ST_LOCKOUT = 2'd3
`else
    ST_SERVING = 2'd2
`endif
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer, stability counter, debounced level
// and a one-cycle pulse on each accepted 0->1 change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic [7:0] cnt_q, cnt_d;

  // The flip happens on the edge that sees the DEBOUNCE_CYCLES-th differing sample.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/ped_request_ctrl.sv
// Debounces two curb push-buttons into a single walk request that is cleared
// by the crosswalk lamps. PED_REQ_LOCKOUT_EN adds a post-walk press lockout.
module ped_request_ctrl
  import ped_req_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_a,
  input  logic             btn_b,
  input  logic             green_walk,
  input  logic             red_hand,
  output logic             walk_req,
  output logic             wait_lamp,
  output logic [CNT_W-1:0] press_count
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 2..255");
  end
  if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 255) begin : g_bad_lockout
    $error("LOCKOUT_CYCLES must be in 1..255");
  end

  logic press_a, press_b, press_any;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) deb_a_inst (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_a),
    .press_o (press_a)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) deb_b_inst (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_b),
    .press_o (press_b)
  );

  assign press_any = press_a | press_b;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             walk_req_q, walk_req_d;
  logic             wait_lamp_q, wait_lamp_d;

`ifdef PED_REQ_LOCKOUT_EN
  localparam logic [7:0] LOCK_LAST = 8'(LOCKOUT_CYCLES - 1);
  logic [7:0] lock_q, lock_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
`ifdef PED_REQ_LOCKOUT_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (press_any && !green_walk) begin
          state_d = ST_PENDING;
          count_d = sat_inc(count_q);
        end
      end
      ST_PENDING: begin
        if (green_walk) state_d = ST_SERVING;
      end
      ST_SERVING: begin
        if (!green_walk && red_hand) begin
`ifdef PED_REQ_LOCKOUT_EN
          state_d = ST_LOCKOUT;
          lock_d  = LOCK_LAST;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef PED_REQ_LOCKOUT_EN
      // Presses seen here are dropped outright; the button must re-arm first.
      ST_LOCKOUT: begin
        if (lock_q == 8'd0) state_d = ST_IDLE;
        else                lock_d  = lock_q - 8'd1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    walk_req_d  = (state_d == ST_PENDING);
    wait_lamp_d = (state_d == ST_PENDING) || (state_d == ST_SERVING);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      walk_req_q  <= 1'b0;
      wait_lamp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      walk_req_q  <= walk_req_d;
      wait_lamp_q <= wait_lamp_d;
    end
  end

`ifdef PED_REQ_LOCKOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lock_q <= '0;
    else        lock_q <= lock_d;
  end
`endif

  assign walk_req    = walk_req_q;
  assign wait_lamp   = wait_lamp_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Self-checking bench for ped_request_ctrl: directed scenarios plus random
// button/lamp traffic, all compared against a behavioural request model.
module tb_ped_request_ctrl;

  localparam int D = 4;
  localparam int L = 8;
`ifdef PED_REQ_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_a = 1'b0, btn_b = 1'b0;
  logic       green_walk = 1'b0, red_hand = 1'b0;
  logic       walk_req, wait_lamp;
  logic [7:0] press_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ped_request_ctrl #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_a       (btn_a),
    .btn_b       (btn_b),
    .green_walk  (green_walk),
    .red_hand    (red_hand),
    .walk_req    (walk_req),
    .wait_lamp   (wait_lamp),
    .press_count (press_count)
  );

  // Behavioural model: raw sample history per button, a level is accepted once
  // the last D synchronized samples (raw delayed by two edges) all disagree.
  bit ra_hist[$], rb_hist[$];
  bit m_deb_a, m_deb_b, m_pa, m_pb;
  bit m_pend, m_serv;
  int m_lock;
  int m_cnt;

  function automatic bit window_flip(input bit h[$], input bit deb);
    for (int j = h.size() - 2 - D; j <= h.size() - 3; j++)
      if (h[j] == deb) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    ra_hist.delete();
    rb_hist.delete();
    for (int j = 0; j < D + 2; j++) begin
      ra_hist.push_back(1'b0);
      rb_hist.push_back(1'b0);
    end
    m_deb_a = 0; m_deb_b = 0; m_pa = 0; m_pb = 0;
    m_pend = 0; m_serv = 0; m_lock = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit pa, pb;
    pa = m_pa;
    pb = m_pb;
    if (m_lock > 0) begin
      m_lock--;
    end else if (m_serv) begin
      if (!green_walk && red_hand) begin
        m_serv = 0;
        if (LOCK_EN) m_lock = L;
      end
    end else if (m_pend) begin
      if (green_walk) begin
        m_pend = 0;
        m_serv = 1;
      end
    end else if ((pa || pb) && !green_walk) begin
      m_pend = 1;
      if (m_cnt < 255) m_cnt++;
    end
    ra_hist.push_back(btn_a);
    rb_hist.push_back(btn_b);
    m_pa = 0;
    m_pb = 0;
    if (window_flip(ra_hist, m_deb_a)) begin m_deb_a = !m_deb_a; m_pa = m_deb_a; end
    if (window_flip(rb_hist, m_deb_b)) begin m_deb_b = !m_deb_b; m_pb = m_deb_b; end
    while (ra_hist.size() > D + 8) void'(ra_hist.pop_front());
    while (rb_hist.size() > D + 8) void'(rb_hist.pop_front());
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      model_edge();
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({walk_req, wait_lamp, press_count} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got walk_req=%b wait_lamp=%b press_count=%0d, expected all 0",
               walk_req, wait_lamp, press_count);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    tick(3);
    n_checks++;
    if ({walk_req, wait_lamp, press_count} !== {m_pend, m_pend | m_serv, 8'(m_cnt)}) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b/%b/%0d expected %b/%b/%0d",
               walk_req, wait_lamp, press_count, m_pend, m_pend | m_serv, m_cnt);
    end
  endtask

  task automatic test_glitch();
    btn_a = 1'b1;
    tick(3);
    btn_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      n_checks++;
      if (walk_req !== 1'b0 || walk_req !== m_pend) begin
        n_fail++;
        $display("FAIL glitch_walk_req cycle %0d: got %b expected 0", i, walk_req);
      end
    end
    n_checks++;
    if (press_count !== 8'd0) begin
      n_fail++;
      $display("FAIL glitch_press_count: got %0d expected 0", press_count);
    end
  endtask

  task automatic serve_request();
    green_walk = 1'b1;
    tick(1);
    n_checks++;
    if (walk_req !== 1'b0 || wait_lamp !== 1'b1) begin
      n_fail++;
      $display("FAIL serve_green: got walk_req=%b wait_lamp=%b expected 0/1", walk_req, wait_lamp);
    end
    green_walk = 1'b0;
    red_hand   = 1'b1;
    tick(1);
    n_checks++;
    if (walk_req !== 1'b0 || wait_lamp !== 1'b0) begin
      n_fail++;
      $display("FAIL serve_red: got walk_req=%b wait_lamp=%b expected 0/0", walk_req, wait_lamp);
    end
    red_hand = 1'b0;
  endtask

  task automatic test_hold();
    int c0;
    c0 = m_cnt;
    btn_a = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      n_checks++;
      if (walk_req !== (i >= D + 3) || walk_req !== m_pend) begin
        n_fail++;
        $display("FAIL hold_walk_req edge %0d: got %b expected %b", i, walk_req, i >= D + 3);
      end
    end
    n_checks++;
    if (press_count !== 8'(c0 + 1) || wait_lamp !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_count_lamp: got count=%0d wait_lamp=%b expected %0d/1",
               press_count, wait_lamp, c0 + 1);
    end
    btn_a = 1'b0;
    serve_request();
    tick(L + 4);
  endtask

  task automatic test_simultaneous();
    int c0;
    c0 = m_cnt;
    btn_a = 1'b1;
    btn_b = 1'b1;
    tick(D + 4);
    n_checks++;
    if (press_count !== 8'(c0 + 1) || walk_req !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_one_request: got count=%0d walk_req=%b expected %0d/1",
               press_count, walk_req, c0 + 1);
    end
    btn_a = 1'b0;
    btn_b = 1'b0;
    serve_request();
    tick(L + 4);
    n_checks++;
    if ({walk_req, wait_lamp, press_count} !== {m_pend, m_pend | m_serv, 8'(m_cnt)}) begin
      n_fail++;
      $display("FAIL simul_settle: got %b/%b/%0d expected %b/%b/%0d",
               walk_req, wait_lamp, press_count, m_pend, m_pend | m_serv, m_cnt);
    end
  endtask

  task automatic test_async_reset();
    btn_a = 1'b1;
    tick(D + 4);
    n_checks++;
    if (walk_req !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pending: got walk_req=%b expected 1", walk_req);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (walk_req !== 1'b0 || wait_lamp !== 1'b0 || press_count !== 8'd0) begin
      n_fail++;
      $display("FAIL areset_immediate: got %b/%b/%0d expected 0/0/0",
               walk_req, wait_lamp, press_count);
    end
    model_reset();
    #1;
    reset = 1'b1;
    for (int i = 1; i <= D + 4; i++) begin
      tick(1);
      n_checks++;
      if (walk_req !== (i >= D + 3) || walk_req !== m_pend) begin
        n_fail++;
        $display("FAIL areset_requalify edge %0d: got %b expected %b", i, walk_req, i >= D + 3);
      end
    end
    btn_a = 1'b0;
    serve_request();
    tick(L + 4);
  endtask

`ifdef PED_REQ_LOCKOUT_EN
  task automatic test_lockout();
    int c0;
    btn_a = 1'b1;
    tick(D + 4);
    btn_a = 1'b0;
    serve_request();
    c0 = m_cnt;
    tick(1);
    btn_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      n_checks++;
      if (walk_req !== 1'b0 || walk_req !== m_pend) begin
        n_fail++;
        $display("FAIL lockout_ignored cycle %0d: got walk_req=%b expected 0", i, walk_req);
      end
    end
    n_checks++;
    if (press_count !== 8'(c0)) begin
      n_fail++;
      $display("FAIL lockout_count: got %0d expected %0d", press_count, c0);
    end
    btn_b = 1'b0;
    tick(D + 4);
    btn_b = 1'b1;
    tick(D + 4);
    n_checks++;
    if (walk_req !== 1'b1 || press_count !== 8'(c0 + 1)) begin
      n_fail++;
      $display("FAIL lockout_after: got walk_req=%b count=%0d expected 1/%0d",
               walk_req, press_count, c0 + 1);
    end
    btn_b = 1'b0;
    serve_request();
    tick(L + 4);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) btn_a = ~btn_a;
      if ($urandom_range(0, 5) == 0) btn_b = ~btn_b;
      if ($urandom_range(0, 9) == 0) green_walk = ~green_walk;
      red_hand = ($urandom_range(0, 2) == 0);
      tick(1);
      n_checks++;
      if ({walk_req, wait_lamp, press_count} !== {m_pend, m_pend | m_serv, 8'(m_cnt)}) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %b/%b/%0d expected %b/%b/%0d",
                 i, walk_req, wait_lamp, press_count, m_pend, m_pend | m_serv, m_cnt);
      end
    end
    btn_a = 1'b0;
    btn_b = 1'b0;
    green_walk = 1'b1;
    tick(2);
    green_walk = 1'b0;
    red_hand = 1'b1;
    tick(2);
    red_hand = 1'b0;
    tick(L + D + 4);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      btn_a = 1'b1;
      tick(D + 4);
      btn_a = 1'b0;
      green_walk = 1'b1;
      tick(1);
      green_walk = 1'b0;
      red_hand = 1'b1;
      tick(1);
      red_hand = 1'b0;
      tick(10);
      n_checks++;
      if (press_count !== 8'(m_cnt)) begin
        n_fail++;
        $display("FAIL saturation iter %0d: got %0d expected %0d", i, press_count, m_cnt);
      end
    end
    n_checks++;
    if (press_count !== 8'd255) begin
      n_fail++;
      $display("FAIL saturation_final: got %0d expected 255", press_count);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_hold();
    test_simultaneous();
    test_async_reset();
`ifdef PED_REQ_LOCKOUT_EN
    test_lockout();
`endif
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
